// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared funct codes, instruction classes and issue FSM states for
//            the multiply/divide issue path.
// Revision : 1.0  initial release
// ============================================================================
package md_pkg;

   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MTHI  = 6'd17;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MTLO  = 6'd19;
   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      LONG = 2'd1,
      MT   = 2'd2,
      MF   = 2'd3
   } md_class_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      MF_WAIT = 2'd2
   } md_state_t;

   // funct[1] distinguishes HI (MFHI) from LO (MFLO) within the MF class.
   function automatic logic md_mf_sel_lo(input logic [5:0] funct);
      return funct[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_decode.sv
`default_nettype none
// ============================================================================
// Module   : md_decode
// Purpose  : Combinational MD-class decode and latency select; shared with the
//            hazard unit.
// Revision : 1.0  initial release
// ============================================================================
module md_decode
   import md_pkg::*;
(
   input  logic [31:0] i_instr,
   output md_class_t   o_class,
   output logic        o_lat_sel
);

   logic [5:0] w_funct;
   logic       w_rtype;
   logic       w_unused_bits;

   assign w_funct       = i_instr[5:0];
   assign w_rtype       = (i_instr[31:26] == 6'd0);
   assign w_unused_bits = ^i_instr[25:6];

   // o_lat_sel=1 selects the divide latency.
   always_comb begin
      o_class   = NONE;
      o_lat_sel = 1'b0;
      if (w_rtype) begin
         case (w_funct)
            FN_MULT, FN_MULTU: o_class = LONG;
            FN_DIV, FN_DIVU: begin
               o_class   = LONG;
               o_lat_sel = 1'b1;
            end
            FN_MTHI, FN_MTLO:  o_class = MT;
            FN_MFHI, FN_MFLO:  o_class = MF;
            default:           o_class = NONE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_issue_ctrl
// Purpose  : EX-stage initiator for the multiply/divide unit: issue, busy
//            tracking, hazard stall, MFHI/MFLO return and cancel.
// Revision : 1.0  initial release
// ============================================================================
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_instr,
   input  logic [31:0] ex_rs_val,
   input  logic [31:0] ex_rt_val,
   input  logic        ex_flush,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic        mdu_start,
   output logic [31:0] mdu_instr,
   output logic [31:0] mdu_a,
   output logic [31:0] mdu_b,
   output logic        mdu_disable,
   output logic        stall,
   output logic        mf_valid,
   output logic [31:0] mf_data,
   output logic        err
);

   localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
   localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_LAT);
   localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_LAT);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   md_state_t          r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_first;
   logic               r_sel;
   logic               r_err;
   logic               r_cancel_d;

   md_class_t          w_class;
   logic               w_lat_sel;
   logic               w_go;
   logic               w_err_set;

   md_decode u_decode (
      .i_instr   (ex_instr),
      .o_class   (w_class),
      .o_lat_sel (w_lat_sel)
   );

   assign w_go  = ex_valid & ~ex_flush & (r_state == IDLE);
   assign mdu_a = ex_rs_val;
   assign mdu_b = ex_rt_val;
   assign err   = r_err;

   always_comb begin
      mdu_start   = 1'b0;
      mdu_instr   = 32'd0;
      mdu_disable = 1'b0;
      stall       = 1'b0;
      mf_valid    = 1'b0;
      mf_data     = 32'd0;
      case (r_state)
         IDLE: begin
            if (w_go) begin
               case (w_class)
                  LONG, MT: begin
                     mdu_start = 1'b1;
                     mdu_instr = ex_instr;
                  end
                  MF: begin
                     mdu_instr = ex_instr;
                     stall     = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         BUSY: begin
            // Non-MD instructions keep flowing underneath a long op.
            stall       = ex_valid & (w_class != NONE);
            mdu_disable = r_first & ex_flush;
         end
         MF_WAIT: begin
            mf_valid = ~ex_flush;
            mf_data  = r_sel ? mdu_lo : mdu_hi;
         end
         default: ;
      endcase
   end

   // An IDLE cycle right after a cancel may still see the unit winding down.
   assign w_err_set = ((r_state == BUSY) & ~mdu_busy) |
                      ((r_state == IDLE) & mdu_busy & ~r_cancel_d);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_first    <= 1'b0;
         r_sel      <= 1'b0;
         r_err      <= 1'b0;
         r_cancel_d <= 1'b0;
      end else begin
         r_cancel_d <= mdu_disable;
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  case (w_class)
                     LONG: begin
                        r_cnt   <= w_lat_sel ? c_DIV_CNT : c_MULT_CNT;
                        r_first <= 1'b1;
                        r_state <= BUSY;
                     end
                     MF: begin
                        r_sel   <= md_mf_sel_lo(ex_instr[5:0]);
                        r_state <= MF_WAIT;
                     end
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               r_first <= 1'b0;
               if (r_first & ex_flush) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - c_CNT_ONE;
                  if (r_cnt <= c_CNT_ONE) begin
                     r_state <= IDLE;
                  end
               end
            end
            MF_WAIT: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_issue_ctrl
// Purpose  : Directed self-checking bench for md_issue_ctrl with a small
//            behavioural multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_md_issue_ctrl;
   import md_pkg::*;

   localparam int          M_LAT  = 5;
   localparam int          D_LAT  = 10;
   localparam logic [31:0] I_MFHI = 32'h0000_0010;
   localparam logic [31:0] I_MTHI = 32'h0000_0011;
   localparam logic [31:0] I_MFLO = 32'h0000_0012;
   localparam logic [31:0] I_MULT = 32'h0000_0018;
   localparam logic [31:0] I_DIV  = 32'h0000_001A;
   localparam logic [31:0] I_DIVU = 32'h0000_001B;
   localparam logic [31:0] I_ADD  = 32'h0000_0020;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [31:0] ex_instr;
   logic [31:0] ex_rs_val;
   logic [31:0] ex_rt_val;
   logic        ex_flush;
   logic        mdu_busy;
   logic [31:0] mdu_hi;
   logic [31:0] mdu_lo;
   logic        mdu_start;
   logic [31:0] mdu_instr;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        mdu_disable;
   logic        stall;
   logic        mf_valid;
   logic [31:0] mf_data;
   logic        err;

   logic        force_idle;
   logic [4:0]  m_cnt;
   logic [31:0] p_hi, p_lo;
   logic [63:0] w_sprod, w_uprod;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int n;

   always #5 clk = ~clk;

   md_issue_ctrl #(.MULT_LAT(M_LAT), .DIV_LAT(D_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .ex_valid    (ex_valid),
      .ex_instr    (ex_instr),
      .ex_rs_val   (ex_rs_val),
      .ex_rt_val   (ex_rt_val),
      .ex_flush    (ex_flush),
      .mdu_busy    (mdu_busy),
      .mdu_hi      (mdu_hi),
      .mdu_lo      (mdu_lo),
      .mdu_start   (mdu_start),
      .mdu_instr   (mdu_instr),
      .mdu_a       (mdu_a),
      .mdu_b       (mdu_b),
      .mdu_disable (mdu_disable),
      .stall       (stall),
      .mf_valid    (mf_valid),
      .mf_data     (mf_data),
      .err         (err)
   );

   // Unit model: results commit when the busy window closes; MT writes at once.
   assign w_sprod = $signed({{32{mdu_a[31]}}, mdu_a}) * $signed({{32{mdu_b[31]}}, mdu_b});
   assign w_uprod = {32'd0, mdu_a} * {32'd0, mdu_b};
   assign mdu_busy = (m_cnt != 5'd0) && !force_idle;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt <= 5'd0; mdu_hi <= 32'd0; mdu_lo <= 32'd0; p_hi <= 32'd0; p_lo <= 32'd0;
      end else if (mdu_disable) begin
         m_cnt <= 5'd0;
      end else if (mdu_start) begin
         case (mdu_instr[5:0])
            FN_MULT:  begin {p_hi, p_lo} <= w_sprod; m_cnt <= 5'(M_LAT); end
            FN_MULTU: begin {p_hi, p_lo} <= w_uprod; m_cnt <= 5'(M_LAT); end
            FN_DIV:   begin
               p_lo <= $signed(mdu_a) / $signed(mdu_b);
               p_hi <= $signed(mdu_a) % $signed(mdu_b);
               m_cnt <= 5'(D_LAT);
            end
            FN_DIVU:  begin p_lo <= mdu_a / mdu_b; p_hi <= mdu_a % mdu_b; m_cnt <= 5'(D_LAT); end
            FN_MTHI:  mdu_hi <= mdu_a;
            FN_MTLO:  mdu_lo <= mdu_a;
            default: ;
         endcase
      end else if (m_cnt != 5'd0) begin
         m_cnt <= m_cnt - 5'd1;
         if (m_cnt == 5'd1) begin
            mdu_hi <= p_hi;
            mdu_lo <= p_lo;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic fl);
      ex_valid  = v;
      ex_instr  = ins;
      ex_rs_val = rs;
      ex_rt_val = rt;
      ex_flush  = fl;
   endtask

   // Counts stalled cycles with inputs held; returns in the first unstalled cycle.
   task automatic count_stall(output int cnt);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!stall) return;
         cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; force_idle = 1'b0;
      drv(1'b0, 32'd0, 32'h11, 32'h22, 1'b0);
      tick(); tick(); #1;
      chk("rst_start", 32'(mdu_start), 32'd0);
      chk("rst_instr", mdu_instr, 32'd0);
      chk("rst_a", mdu_a, 32'h11);
      chk("rst_b", mdu_b, 32'h22);
      chk("rst_dis", 32'(mdu_disable), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mfv", 32'(mf_valid), 32'd0);
      chk("rst_mfd", mf_data, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      reset = 1'b0;

      // MULT 3 * -4, then MFLO and MFHI
      tick(); drv(1'b1, I_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0); #1;
      chk("mult_start", 32'(mdu_start), 32'd1);
      chk("mult_instr", mdu_instr, I_MULT);
      chk("mult_stall", 32'(stall), 32'd0);
      tick(); drv(1'b1, I_MFLO, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("mflo_stall", 32'(n), 32'd6);
      chk("mflo_valid", 32'(mf_valid), 32'd1);
      chk("mflo_data", mf_data, 32'hFFFF_FFF4);
      tick(); drv(1'b1, I_MFHI, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("mfhi_stall", 32'(n), 32'd1);
      chk("mfhi_data", mf_data, 32'hFFFF_FFFF);
      chk("mult_err", 32'(err), 32'd0);

      // DIVU 17 / 5 with an ADD underneath
      tick(); drv(1'b1, I_DIVU, 32'd17, 32'd5, 1'b0); #1;
      chk("divu_start", 32'(mdu_start), 32'd1);
      tick(); drv(1'b1, I_ADD, 32'd1, 32'd2, 1'b0); #1;
      chk("add_stall", 32'(stall), 32'd0);
      chk("add_instr", mdu_instr, 32'd0);
      tick(); drv(1'b1, I_MFHI, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("divu_stall", 32'(n), 32'd10);
      chk("divu_hi", mf_data, 32'd2);
      tick(); drv(1'b1, I_MFLO, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("divu_lo_stall", 32'(n), 32'd1);
      chk("divu_lo", mf_data, 32'd3);

      // MTHI then MFHI
      tick(); drv(1'b1, I_MTHI, 32'h1234, 32'd0, 1'b0); #1;
      chk("mthi_start", 32'(mdu_start), 32'd1);
      chk("mthi_stall", 32'(stall), 32'd0);
      tick(); drv(1'b1, I_MFHI, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("mt_mf_stall", 32'(n), 32'd1);
      chk("mt_mf_data", mf_data, 32'h1234);

      // DIV cancelled in its first BUSY cycle
      tick(); drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0); reset = 1'b1;
      tick(); reset = 1'b0;
      drv(1'b1, I_DIV, 32'd100, 32'd7, 1'b0); #1;
      chk("div_start", 32'(mdu_start), 32'd1);
      tick(); drv(1'b1, I_ADD, 32'd0, 32'd0, 1'b1); #1;
      chk("cancel_dis", 32'(mdu_disable), 32'd1);
      tick(); drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0); #1;
      chk("cancel_pulse", 32'(mdu_disable), 32'd0);
      tick(); drv(1'b1, I_MFLO, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("cancel_idle", 32'(n), 32'd1);
      chk("cancel_lo", mf_data, 32'd0);
      chk("cancel_err", 32'(err), 32'd0);

      // Flush in the second BUSY cycle must not cancel
      tick(); drv(1'b1, I_DIV, 32'd100, 32'd7, 1'b0); #1;
      chk("div2_start", 32'(mdu_start), 32'd1);
      tick(); drv(1'b1, I_ADD, 32'd0, 32'd0, 1'b0);
      tick(); drv(1'b1, I_ADD, 32'd0, 32'd0, 1'b1); #1;
      chk("late_dis", 32'(mdu_disable), 32'd0);
      tick(); drv(1'b1, I_MFLO, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("late_stall", 32'(n), 32'd9);
      chk("late_lo", mf_data, 32'd14);

      // Flush during MF_WAIT
      tick(); drv(1'b1, I_MFHI, 32'd0, 32'd0, 1'b0); count_stall(n);
      ex_flush = 1'b1; #1;
      chk("mfw_flush_valid", 32'(mf_valid), 32'd0);

      // Reset in BUSY cycle 3, then a fresh MULT
      tick(); drv(1'b1, I_MULT, 32'd6, 32'd7, 1'b0); #1;
      chk("m3_start", 32'(mdu_start), 32'd1);
      tick(); drv(1'b1, I_MFLO, 32'd0, 32'd0, 1'b0);
      tick(); tick(); reset = 1'b1; #1;
      chk("m3_busy_stall", 32'(stall), 32'd1);
      tick(); reset = 1'b0; drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0); #1;
      chk("mrst_start", 32'(mdu_start), 32'd0);
      chk("mrst_instr", mdu_instr, 32'd0);
      chk("mrst_dis", 32'(mdu_disable), 32'd0);
      chk("mrst_stall", 32'(stall), 32'd0);
      chk("mrst_mfv", 32'(mf_valid), 32'd0);
      chk("mrst_mfd", mf_data, 32'd0);
      chk("mrst_err", 32'(err), 32'd0);
      tick(); drv(1'b1, I_MULT, 32'd6, 32'd7, 1'b0); #1;
      chk("m4_start", 32'(mdu_start), 32'd1);
      tick(); drv(1'b1, I_MFLO, 32'd0, 32'd0, 1'b0); count_stall(n);
      chk("m4_stall", 32'(n), 32'd6);
      chk("m4_lo", mf_data, 32'd42);
      chk("m4_err", 32'(err), 32'd0);

      // Unit drops busy early: sticky err
      tick(); drv(1'b1, I_MULT, 32'd2, 32'd2, 1'b0); #1;
      tick(); drv(1'b0, 32'd0, 32'd0, 32'd0, 1'b0); force_idle = 1'b1; #1;
      chk("err_pre", 32'(err), 32'd0);
      tick(); force_idle = 1'b0; #1;
      chk("err_set", 32'(err), 32'd1);
      repeat (8) tick();
      #1;
      chk("err_sticky", 32'(err), 32'd1);
      reset = 1'b1;
      tick(); reset = 1'b0; #1;
      chk("err_clear", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side initiator for the multiply/divide unit. It sits in the EX stage, decodes MD-class instructions, and drives the unit's start/instr/operand/DISABLE inputs. It tracks the unit's busy window with its own latency counter, stalls the pipeline on MD hazards, and returns MFHI/MFLO results one cycle after issue.

## Interface
- MULT_LAT, default 5: busy cycles for MULT/MULTU after the start edge.
- DIV_LAT, default 10: busy cycles for DIV/DIVU after the start edge.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ex_valid  in  1  EX holds a live instruction.
- ex_instr  in  32  EX instruction word.
- ex_rs_val  in  32  forwarded rs value.
- ex_rt_val  in  32  forwarded rt value.
- ex_flush  in  1  exception/interrupt on the instruction ahead; cancels the EX instruction and the most recent long issue.
- mdu_busy  in  1  unit busy.
- mdu_hi  in  32  unit HI output.
- mdu_lo  in  32  unit LO output.
- mdu_start  out  1  issue strobe, combinational.
- mdu_instr  out  32  instruction to unit; 0 when not issuing.
- mdu_a  out  32  = ex_rs_val.
- mdu_b  out  32  = ex_rt_val.
- mdu_disable  out  1  cancel strobe.
- stall  out  1  freeze IF/ID/EX.
- mf_valid  out  1  mf_data valid this cycle.
- mf_data  out  32  MFHI/MFLO result.
- err  out  1  sticky busy-mismatch flag.

## Operation
- Decode applies only when opcode = 0. Funct 24–27 is LONG (MULT, MULTU, DIV, DIVU). Funct 17/19 is MT (MTHI, MTLO). Funct 16/18 is MF (MFHI, MFLO). Anything else is NONE.
- `go` = ex_valid & !ex_flush & state==IDLE.
- States: IDLE, BUSY, MF_WAIT.
- IDLE, go, LONG:
  - mdu_start=1, mdu_instr=ex_instr.
  - Load cnt = MULT_LAT for funct 24/25, DIV_LAT for funct 26/27.
  - Set first=1 and go to BUSY.
  - stall=0, so the instruction leaves EX.
- IDLE, go, MT: mdu_start=1, mdu_instr=ex_instr, stay IDLE, no stall.
- IDLE, go, MF:
  - mdu_start=0, mdu_instr=ex_instr, stall=1.
  - Save funct[1] (0=HI, 1=LO) and go to MF_WAIT.
- MF_WAIT:
  - stall=0, mdu_instr=0.
  - mf_valid = !ex_flush; mf_data = saved sel ? mdu_lo : mdu_hi.
  - Go to IDLE.
  - If ex_flush: mf_valid=0, go to IDLE.
- BUSY:
  - stall = ex_valid & class≠NONE. Non-MD instructions proceed.
  - mdu_start=0, mdu_instr=0.
  - first cycle with ex_flush: mdu_disable=1, go to IDLE, cnt=0.
  - otherwise cnt decrements; at cnt==1 the next state is IDLE, so the result is visible on mdu_hi/mdu_lo in the following cycle.
  - first clears after one cycle.
- ex_flush in IDLE: no issue, no stall, mdu_instr=0.
- err is set, and held until reset, when either occurs:
  - state==BUSY & !mdu_busy;
  - state==IDLE & mdu_busy & the previous cycle was not a cancel cycle.
- Reset mid-operation: state←IDLE, cnt←0, first←0, err←0. The unit shares reset, so no disable is needed.

## Timing
- Reset values:
  - mdu_start 0, mdu_instr 0, mdu_a/mdu_b follow inputs, mdu_disable 0.
  - stall 0, mf_valid 0, mf_data 0, err 0.
- Long op issued at edge E0: BUSY for cycles E0..E0+LAT−1, IDLE at E0+LAT. A back-to-back MD instruction stalls LAT cycles.
- MF: stall exactly 1 cycle. mf_valid in the cycle after issue.
- MT: zero stall. A following MF one cycle later reads the new value, because the unit updates HI/LO at the MT edge.
- Cancel window: only the first BUSY cycle. A later ex_flush does not cancel.
- mdu_start, mdu_instr, mdu_disable and stall are combinational from inputs and state. mf_data is combinational from mdu_hi/mdu_lo.

## Structure
- Shared package `md_pkg`:
  - funct constants: FN_MFHI=16, FN_MTHI=17, FN_MFLO=18, FN_MTLO=19, FN_MULT=24, FN_MULTU=25, FN_DIV=26, FN_DIVU=27;
  - class enum {NONE, LONG, MT, MF};
  - state enum {IDLE, BUSY, MF_WAIT}.
- Sub-module `md_decode`: combinational instr→class plus lat_sel. It is reused by the hazard unit.

## Test plan
- MULT, rs=3, rt=−4 with MULT_LAT=5, then MFLO, then MFHI:
  - MFLO stalls 5 BUSY cycles plus 1 MF cycle;
  - mf_data=0xFFFFFFF4, then 0xFFFFFFFF;
  - err=0.
- DIVU, rs=17, rt=5, followed by ADD: ADD never stalls. A following MFHI returns 2 and MFLO returns 3, with stall lasting 10 cycles.
- MTHI 0x1234 then MFHI: 0 stall on MTHI, mf_data=0x1234 after a 1-cycle stall.
- DIV issued, ex_flush in the first BUSY cycle:
  - mdu_disable pulses 1 cycle, state returns to IDLE;
  - a later MFLO returns the old LO (0 after reset);
  - err=0.
- ex_flush during MF_WAIT gives mf_valid=0. Reset asserted at BUSY cycle 3 gives all outputs at reset values next cycle, and a following MULT issues normally.
- Force mdu_busy=0 during BUSY: err=1 and stays 1 until reset.
